rom_ram_scan_mem: RTL and testbench

- Parametrised successor of the fixed 4-entry LED lookup: a registered memory whose low NROM words are constant ROM and whose remaining words are writable RAM.
- Two modes:
  - Manual: switch-driven address, read and write.
  - Scan: an internal counter steps through every address at a divided rate, so a board can display the whole memory on LEDs/LCD without user input.
- Write attempts to ROM are flagged and counted.

---
 rtl/rom_ram_scan_mem.sv | 116 +++++++++++
 tb/tb_rom_ram_scan_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rom_ram_scan_mem.sv
// Registered memory: low NROM words are constant ROM, the rest writable RAM.
// Manual mode reads/writes a switch address; scan mode sweeps all addresses at a divided rate.
module rom_ram_scan_mem #(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_ADDR = 3,
  parameter int NROM       = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [NBITS_ADDR-1:0] addr,
  input  logic                  we,
  input  logic [NBITS_DATA-1:0] wdata,
  output logic [NBITS_DATA-1:0] rdata,
  output logic [NBITS_ADDR-1:0] raddr,
  output logic                  rvalid,
  output logic                  wr_err,
  output logic [7:0]            err_cnt
);

  localparam int DEPTH = 2 ** NBITS_ADDR;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NBITS_ADDR:0]   NROM_W   = (NBITS_ADDR + 1)'(NROM);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
  localparam logic [NBITS_ADDR-1:0] ADDR_ONE = NBITS_ADDR'(1);

  function automatic logic [NBITS_DATA-1:0] rom_word(input logic [NBITS_ADDR-1:0] a);
    logic [31:0] w;
    w = 32'd3 * (32'(a) + 32'd1);
    return w[NBITS_DATA-1:0];
  endfunction

  function automatic logic is_rom(input logic [NBITS_ADDR-1:0] a);
    return {1'b0, a} < NROM_W;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic                  mode_q;
  logic [NBITS_ADDR-1:0] scan_addr;
  logic [NBITS_ADDR-1:0] scan_addr_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic [NBITS_ADDR-1:0] asel;
  logic [NBITS_DATA-1:0] rd_word;
  logic                  wr_ram;
  logic                  wr_rom;
  logic [NBITS_DATA-1:0] ram [DEPTH];

  logic [NBITS_DATA-1:0] rdata_p1;
  logic [NBITS_ADDR-1:0] raddr_p1;
  logic                  vld_p1;
  logic                  wr_err_p1;
  logic [7:0]            err_cnt_p1;

  // The address read on a scan edge is the one the scan counter moves to, so
  // the entry edge reads 0 and every address is shown for SCAN_DIV cycles.
  always_comb begin
    scan_addr_nxt = scan_addr;
    div_nxt       = div_cnt;
    if (!mode_q) begin
      scan_addr_nxt = '0;
      div_nxt       = '0;
    end else if (div_cnt == DIV_LAST) begin
      scan_addr_nxt = scan_addr + ADDR_ONE;
      div_nxt       = '0;
    end else begin
      div_nxt = div_cnt + DIV_ONE;
    end
  end

  always_comb begin
    asel    = mode ? scan_addr_nxt : addr;
    rd_word = is_rom(asel) ? rom_word(asel) : ram[asel];
    wr_ram  = !mode && we && !is_rom(addr);
    wr_rom  = !mode && we && is_rom(addr);
  end

  // Stage p1: registered read, write commit and error bookkeeping.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      rdata_p1   <= '0;
      raddr_p1   <= '0;
      vld_p1     <= 1'b0;
      wr_err_p1  <= 1'b0;
      err_cnt_p1 <= 8'd0;
      scan_addr  <= '0;
      div_cnt    <= '0;
      mode_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      rdata_p1  <= rd_word;
      raddr_p1  <= asel;
      vld_p1    <= 1'b1;
      wr_err_p1 <= wr_rom;
      mode_q    <= mode;
      if (wr_rom) err_cnt_p1 <= sat_inc8(err_cnt_p1);
      if (wr_ram) ram[addr] <= wdata;
      if (mode) begin
        scan_addr <= scan_addr_nxt;
        div_cnt   <= div_nxt;
      end
    end
  end

  assign rdata   = rdata_p1;
  assign raddr   = raddr_p1;
  assign rvalid  = vld_p1;
  assign wr_err  = wr_err_p1;
  assign err_cnt = err_cnt_p1;

endmodule

// File: tb/tb_rom_ram_scan_mem.sv
// Directed bench for rom_ram_scan_mem: a reference model pushes expected outputs
// to a scoreboard queue as each step is driven; they are popped after the edge.
module tb_rom_ram_scan_mem;

  localparam int SCAN_DIV = 2;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic [2:0] addr  = '0;
  logic       we    = 1'b0;
  logic [3:0] wdata = '0;
  logic [3:0] rdata;
  logic [2:0] raddr;
  logic       rvalid;
  logic       wr_err;
  logic [7:0] err_cnt;

  rom_ram_scan_mem #(
    .NBITS_DATA(4), .NBITS_ADDR(3), .NROM(4), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk_2(clk_2), .reset(reset), .mode(mode), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .raddr(raddr), .rvalid(rvalid),
    .wr_err(wr_err), .err_cnt(err_cnt)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct packed {
    logic [3:0] rdata;
    logic [2:0] raddr;
    logic       rvalid;
    logic       wr_err;
    logic [7:0] err_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model state
  logic [3:0] rom_tab [4] = '{4'd3, 4'd6, 4'd9, 4'd12};
  logic [3:0] m_ram [8];
  logic [7:0] m_err_cnt = 8'd0;
  logic       m_prev    = 1'b0;
  int         m_scan_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic r, input logic m, input logic [2:0] a,
                            input logic w, input logic [3:0] d);
    exp_t e;
    int   sa;
    e = '0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_ram[i] = 4'd0;
      m_err_cnt  = 8'd0;
      m_prev     = 1'b0;
      m_scan_cnt = 0;
    end else begin
      if (m) begin
        m_scan_cnt = m_prev ? m_scan_cnt + 1 : 0;
        sa = (m_scan_cnt / SCAN_DIV) % 8;
      end else begin
        sa = int'(a);
      end
      e.raddr  = 3'(sa);
      e.rdata  = (sa < 4) ? rom_tab[sa] : m_ram[sa];
      e.rvalid = 1'b1;
      e.wr_err = !m && w && (a < 3'd4);
      if (e.wr_err && m_err_cnt != 8'd255) m_err_cnt = m_err_cnt + 8'd1;
      if (!m && w && a >= 3'd4) m_ram[a] = d;
      m_prev = m;
    end
    e.err_cnt = m_err_cnt;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic m, input logic [2:0] a,
                      input logic w, input logic [3:0] d);
    exp_t e;
    @(negedge clk_2);
    reset = r; mode = m; addr = a; we = w; wdata = d;
    model_push(r, m, a, w, d);
    @(posedge clk_2);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("rdata",   32'(rdata),   32'(e.rdata));
      check("raddr",   32'(raddr),   32'(e.raddr));
      check("rvalid",  32'(rvalid),  32'(e.rvalid));
      check("wr_err",  32'(wr_err),  32'(e.wr_err));
      check("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
    end
  endtask

  initial begin
    // Reset state
    step(1, 0, 3'd0, 0, 4'h0);
    step(1, 0, 3'd0, 0, 4'h0);

    // ROM reads
    for (int i = 0; i < 4; i++) step(0, 0, 3'(i), 0, 4'h0);
    check("rom3_const", 32'(rdata), 32'd12);

    // RAM write with read-before-write, then read back
    step(0, 0, 3'd5, 1, 4'hA);
    check("rbw_old", 32'(rdata), 32'd0);
    step(0, 0, 3'd5, 0, 4'h0);
    check("ram5_new", 32'(rdata), 32'hA);

    // Rejected ROM write
    step(0, 0, 3'd2, 1, 4'hF);
    step(0, 0, 3'd2, 0, 4'h0);
    step(0, 0, 3'd2, 0, 4'h0);

    // Write addr 7 then scan with we held high
    step(0, 0, 3'd7, 1, 4'h5);
    for (int i = 0; i < 18; i++) step(0, 1, 3'd4, 1, 4'hF);
    for (int i = 4; i < 8; i++) step(0, 0, 3'(i), 0, 4'h0);

    // Leave scan mid-sweep, then re-enter from zero
    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 0, 4'h0);
    step(0, 0, 3'd6, 0, 4'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 0, 4'h0);

    // Reset during scan, with a write presented on the reset edge
    step(1, 1, 3'd6, 1, 4'h9);
    step(0, 0, 3'd5, 0, 4'h0);
    check("ram5_cleared", 32'(rdata), 32'd0);
    step(0, 0, 3'd0, 0, 4'h0);
    step(0, 0, 3'd6, 0, 4'h0);

    // Saturating error counter
    for (int i = 0; i < 300; i++) step(0, 0, 3'd1, 1, 4'hF);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    step(0, 0, 3'd1, 0, 4'h0);
    step(0, 0, 3'd1, 0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
